// File: rtl/reg_file_scb_pkg.sv
// Shared defaults and address type for the IITB-RISC register file.
package reg_file_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int ADDR_W       = $clog2(DEF_NUM_REGS);
    localparam int PC_IDX       = DEF_NUM_REGS - 1;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_scb_if.sv
// Register file bus: read ports, writeback, PC update, scoreboard control.
interface reg_file_scb_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [ADDR_W-1:0]   rd_addr1;
    logic [ADDR_W-1:0]   rd_addr2;
    logic [DATA_W-1:0]   rd_data1;
    logic [DATA_W-1:0]   rd_data2;
    logic                rd_busy1;
    logic                rd_busy2;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                pc_wr;
    logic [DATA_W-1:0]   pc_next;
    logic [DATA_W-1:0]   pc;
    logic                claim_en;
    logic [ADDR_W-1:0]   claim_addr;
    logic                flush;
    logic [NUM_REGS-1:0] busy_vec;

    // Pipeline side (decode/issue/writeback).
    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pc_wr, pc_next,
               claim_en, claim_addr, flush,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, pc, busy_vec
    );

    // Register file side.
    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pc_wr, pc_next,
               claim_en, claim_addr, flush,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, pc, busy_vec
    );

endinterface

// File: rtl/reg_file_scb_busy.sv
// Pending-write scoreboard: one busy bit per register, claim/clear/flush.
module reg_busy_scb #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                claim_en_i,
    input  logic [ADDR_W-1:0]   claim_addr_i,
    input  logic                flush_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [ADDR_W-1:0]   rd_addr1_i,
    input  logic [ADDR_W-1:0]   rd_addr2_i,
    output logic [NUM_REGS-1:0] busy_vec_o,
    output logic                rd_busy1_o,
    output logic                rd_busy2_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Next state: flush beats a new claim, a new claim beats the old producer's writeback.
    // Out-of-range claim/write addresses never match any bit, so they are ignored.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (flush_i)
                busy_d[i] = 1'b0;
            else if (claim_en_i && claim_addr_i == ADDR_W'(i))
                busy_d[i] = 1'b1;
            else if (wr_en_i && wr_addr_i == ADDR_W'(i))
                busy_d[i] = 1'b0;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // Arriving writeback data is bypassed, so its reader need not stall.
    always_comb begin
        rd_busy1_o = 1'b0;
        rd_busy2_o = 1'b0;
        if (32'(rd_addr1_i) < NUM_REGS)
            rd_busy1_o = busy_q[rd_addr1_i] && !(wr_en_i && wr_addr_i == rd_addr1_i);
        if (32'(rd_addr2_i) < NUM_REGS)
            rd_busy2_o = busy_q[rd_addr2_i] && !(wr_en_i && wr_addr_i == rd_addr2_i);
    end

    assign busy_vec_o = busy_q;

endmodule

// File: rtl/reg_file_scb.sv
// Register file with write-through bypass, PC register and busy scoreboard.
module reg_file_scb
    import reg_file_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                NUM_REGS = DEF_NUM_REGS,
    parameter logic [DATA_W-1:0] RST_PC   = '0
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_scb_if.slave bus
);

    localparam int AW  = $clog2(NUM_REGS);
    localparam int PCI = NUM_REGS - 1;
    localparam logic [AW-1:0] PC_A = AW'(PCI);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic                            wr_ok;

    assign wr_ok = bus.wr_en && (32'(bus.wr_addr) < NUM_REGS);

    // Bypassed read: value the register will hold after this edge.
    function automatic logic [DATA_W-1:0] rd_mux(
        input logic [AW-1:0]                   a,
        input logic [NUM_REGS-1:0][DATA_W-1:0] r,
        input logic                            we,
        input logic [AW-1:0]                   wa,
        input logic [DATA_W-1:0]               wd,
        input logic                            pw,
        input logic [DATA_W-1:0]               pn
    );
        if (32'(a) >= NUM_REGS)   return '0;
        if (we && wa == a)        return wd;
        if (pw && a == PC_A)      return pn;
        return r[a];
    endfunction

    assign bus.rd_data1 = rd_mux(bus.rd_addr1, regs_q, wr_ok, bus.wr_addr, bus.wr_data,
                                 bus.pc_wr, bus.pc_next);
    assign bus.rd_data2 = rd_mux(bus.rd_addr2, regs_q, wr_ok, bus.wr_addr, bus.wr_data,
                                 bus.pc_wr, bus.pc_next);
    assign bus.pc       = regs_q[PCI];

    // Next state: sequential PC first, so a writeback to the PC slot overrides it.
    always_comb begin
        regs_d = regs_q;
        if (bus.pc_wr) regs_d[PCI]         = bus.pc_next;
        if (wr_ok)     regs_d[bus.wr_addr] = bus.wr_data;
    end

    // Storage; reset clears everything except the PC slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q      <= '0;
            regs_q[PCI] <= RST_PC;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_busy_scb #(.NUM_REGS(NUM_REGS), .ADDR_W(AW)) u_scb (
        .clk          (clk),
        .rst          (rst),
        .claim_en_i   (bus.claim_en),
        .claim_addr_i (bus.claim_addr),
        .flush_i      (bus.flush),
        .wr_en_i      (bus.wr_en),
        .wr_addr_i    (bus.wr_addr),
        .rd_addr1_i   (bus.rd_addr1),
        .rd_addr2_i   (bus.rd_addr2),
        .busy_vec_o   (bus.busy_vec),
        .rd_busy1_o   (bus.rd_busy1),
        .rd_busy2_o   (bus.rd_busy2)
    );

endmodule

// File: doc/reg_file_scb.md
Name: reg_file_scb

Overview:
Parametrised register file for the pipelined IITB-RISC core.
- N general registers; the top index doubles as the architectural PC.
- Two combinational read ports with write-through bypass; one writeback port; a dedicated PC update port.
- An integrated busy scoreboard (one pending-write bit per register) feeds decode-stage hazard detection.

Parameters:
DATA_W, 16, register/data width in bits
NUM_REGS, 8, number of registers (>=2)
ADDR_W, $clog2(NUM_REGS), register address width (3 at default)
PC_IDX, NUM_REGS-1, index of the register that holds the PC
RST_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
rd_addr1  in  ADDR_W  read port 1 address
rd_addr2  in  ADDR_W  read port 2 address
rd_data1  out  DATA_W  read port 1 data (bypassed)
rd_data2  out  DATA_W  read port 2 data (bypassed)
rd_busy1  out  1  register at rd_addr1 has an outstanding producer
rd_busy2  out  1  register at rd_addr2 has an outstanding producer
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
pc_wr  in  1  sequential PC update strobe
pc_next  in  DATA_W  next PC value
pc  out  DATA_W  stored PC (registered, no bypass)
claim_en  in  1  issue stage marks a destination register busy
claim_addr  in  ADDR_W  destination being claimed
flush  in  1  clear all busy bits (pipeline flush)
busy_vec  out  NUM_REGS  raw scoreboard state

Behaviour:
- Reset (async, on rst rising edge or while rst=1):
  - all registers = 0, except register PC_IDX = RST_PC;
  - busy_vec = 0, so rd_busy1/2 = 0;
  - pc = RST_PC;
  - rd_data* are combinational from the reset state.
- Register update, on posedge clk:
  - if wr_en: reg[wr_addr] <= wr_data;
  - if pc_wr and not (wr_en and wr_addr==PC_IDX): reg[PC_IDX] <= pc_next;
  - wr_en to PC_IDX beats pc_wr in the same cycle (jump/branch writeback overrides the sequential increment).
- Reads are combinational, 0-cycle latency. Priority per port:
  - (a) wr_en and wr_addr==rd_addr -> wr_data;
  - (b) rd_addr==PC_IDX and pc_wr -> pc_next;
  - (c) otherwise the stored value.
  - The bypass always matches the value the register will hold after the edge.
- pc output = stored reg[PC_IDX] only; no bypass.
- Scoreboard, next-state per bit i on posedge clk:
  - flush -> 0 (beats everything, including a same-cycle claim);
  - else claim_en and claim_addr==i -> 1 (a new producer beats a same-cycle writeback of the old one);
  - else wr_en and wr_addr==i -> 0;
  - else hold.
- pc_wr never touches busy bits. wr_en to PC_IDX clears busy[PC_IDX].
- rd_busyN = busy[rd_addrN] and not (wr_en and wr_addr==rd_addrN). Arriving writeback data is bypassed, so the reader is not stalled.
- A claim made in the current cycle is not visible on rd_busy until the next cycle.
- Addresses >= NUM_REGS (non-power-of-two NUM_REGS):
  - writes and claims are ignored;
  - reads return 0 with busy 0.
- Reset asserted mid-operation forces the reset state immediately; in-flight writes that cycle are lost.
- Width rules: all data are DATA_W with no extension or truncation; busy_vec bit i corresponds to register i.

Decomposition:
- Shared package reg_file_pkg holds the DATA_W/NUM_REGS defaults, the PC_IDX localparam and the reg_addr_t typedef (logic [ADDR_W-1:0]).
- One natural sub-module: reg_busy_scb, the NUM_REGS-bit scoreboard with claim/clear/flush and the rd_busy masking.
- Storage and bypass muxes stay in the top level.

Test Plan:
1. Reset: assert rst mid-clock with RST_PC=16'h0010 -> pc=0010, rd_data for addr 3 = 0000, busy_vec=00 immediately, before the next edge.
2. Bypass: wr_en=1, wr_addr=2, wr_data=ABCD, rd_addr1=2 in the same cycle -> rd_data1=ABCD combinationally; after the edge, with wr_en=0, rd_data1 is still ABCD.
3. PC priority: pc_wr=1, pc_next=0042 together with wr_en=1, wr_addr=7, wr_data=1234 -> rd_data on addr 7 = 1234 that cycle; pc=1234 after the edge.
4. Scoreboard: claim addr 5 -> next cycle busy_vec[5]=1 and rd_busy1=1 (rd_addr1=5); wr_en to 5 -> rd_busy1=0 in the same cycle and busy_vec[5]=0 after the edge.
5. Collisions: claim 4 and writeback 4 in the same cycle -> busy[4]=1 after the edge. Claim 4 with flush -> busy_vec=00 after the edge.
6. Sequential PC: pc_wr each cycle with pc_next=pc+1 for 4 cycles from 0010 -> pc=0011, 0012, 0013, 0014; busy bits unchanged.
